// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: op encodings, FSM states, default widths.
package lsu_pkg;

  localparam int unsigned LSU_AW     = 5;
  localparam int unsigned LSU_DW     = 8;
  localparam int unsigned LSU_MAXLEN = 4;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'b00,
    OP_STORE = 2'b01,
    OP_FILL  = 2'b10,
    OP_NOP   = 2'b11
  } lsu_op_e;

  typedef enum logic [1:0] {
    StIdle,
    StWrite,
    StRead,
    StResp
  } lsu_state_e;

endpackage

// File: rtl/load_store_unit.sv
// Core-side initiator for the 32x8 data memory: load/store/fill bursts over valid/ready.
// Optional write protection above PROT_BASE is enabled by defining LSU_WPROT_EN.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned   AW        = LSU_AW,
  parameter int unsigned   DW        = LSU_DW,
  parameter int unsigned   MAXLEN    = LSU_MAXLEN,
  parameter logic [AW-1:0] PROT_BASE = AW'(5'h1B)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [1:0]    req_op,
  input  logic [AW-1:0] req_addr,
  input  logic [1:0]    req_len,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_last,
  output logic          busy,
  output logic          err,
  input  logic          err_clr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata
);

  localparam int unsigned LW = (MAXLEN > 1) ? $clog2(MAXLEN) : 1;

  lsu_state_e    state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  lsu_op_e       op;

  assign op = lsu_op_e'(req_op);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    unique case (state_q)
      StIdle: begin
        // Reserved op is swallowed here without touching the memory port.
        if (req_valid && op != OP_NOP) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = LW'(req_len);
          if (op == OP_LOAD) begin
            state_d = StRead;
          end else begin
            state_d = StWrite;
            if (op == OP_STORE) cnt_d = '0;
          end
        end
      end
      StWrite: begin
        addr_d = addr_q + 1'b1;
        if (cnt_q == '0) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StRead: begin
        rdata_d = mem_rdata;
        state_d = StResp;
      end
      StResp: begin
        if (rsp_ready) begin
          if (cnt_q == '0) begin
            state_d = StIdle;
          end else begin
            addr_d  = addr_q + 1'b1;
            cnt_d   = cnt_q - 1'b1;
            state_d = StRead;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      addr_q  <= '0;
      cnt_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign req_ready = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign rsp_valid = (state_q == StResp);
  assign rsp_last  = (state_q == StResp) && (cnt_q == '0);
  assign rsp_data  = rdata_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

`ifdef LSU_WPROT_EN
  logic blocked;
  logic err_q;

  // A blocked byte still costs its cycle so burst timing is unchanged.
  assign blocked = (state_q == StWrite) && (addr_q >= PROT_BASE);
  assign mem_we  = (state_q == StWrite) && !blocked;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (blocked) begin
      err_q <= 1'b1;
    end else if (err_clr) begin
      err_q <= 1'b0;
    end
  end

  assign err = err_q;
`else
  logic unused_cfg;

  assign mem_we     = (state_q == StWrite);
  assign err        = 1'b0;
  assign unused_cfg = ^{err_clr, PROT_BASE};
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural 32x8 memory and a response scoreboard.
module tb_load_store_unit;

  logic       clock = 1'b0;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_op;
  logic [4:0] req_addr;
  logic [1:0] req_len;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_last;
  logic       busy;
  logic       err;
  logic       err_clr;
  logic [4:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_we;
  logic [7:0] mem_rdata;

  logic [7:0] mem [32];

  int checks = 0;
  int passes = 0;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } rsp_t;
  rsp_t exp_q[$];

  always #5 clock = ~clock;

  load_store_unit dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_addr  (req_addr),
    .req_len   (req_len),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_last  (rsp_last),
    .busy      (busy),
    .err       (err),
    .err_clr   (err_clr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata)
  );

  assign mem_rdata = mem[mem_addr];

  always @(posedge clock) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Monitor: every accepted response byte is matched against the scoreboard.
  always @(negedge clock) begin
    if (!reset && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rsp", 1, 0);
      end else begin
        rsp_t e;
        e = exp_q.pop_front();
        chk("rsp_data", int'(rsp_data), int'(e.data));
        chk("rsp_last", int'(rsp_last), int'(e.last));
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, int'(req_ready), 1);
    chk({tag, "_rsp_valid"}, int'(rsp_valid), 0);
    chk({tag, "_rsp_data"},  int'(rsp_data), 0);
    chk({tag, "_rsp_last"},  int'(rsp_last), 0);
    chk({tag, "_busy"},      int'(busy), 0);
    chk({tag, "_err"},       int'(err), 0);
    chk({tag, "_mem_we"},    int'(mem_we), 0);
    chk({tag, "_mem_addr"},  int'(mem_addr), 0);
    chk({tag, "_mem_wdata"}, int'(mem_wdata), 0);
  endtask

  // Presents a request at a negedge and returns #1 after the accepting edge.
  task automatic do_req(input logic [1:0] op, input logic [4:0] addr, input logic [1:0] len,
                        input logic [7:0] wd);
    int n = 0;
    @(negedge clock);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_len   = len;
    req_wdata = wd;
    while (!req_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (n >= 50) chk("req_accept_timeout", 0, 1);
    @(posedge clock);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (n >= 200) chk({tag, "_drain_timeout"}, 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] held;
    int         n;
    rsp_t       e;

    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
    reset     = 1'b1;
    req_valid = 1'b0;
    req_op    = 2'b00;
    req_addr  = '0;
    req_len   = '0;
    req_wdata = '0;
    rsp_ready = 1'b1;
    err_clr   = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check_reset_outputs("rst");
    @(negedge clock);
    reset = 1'b0;

    // 1: reset lands after the bytes at 2 and 3 have been written.
    do_req(2'b10, 5'd2, 2'd3, 8'hA5);
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    check_reset_outputs("midfill");
    @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    chk("fill_rst_m2", int'(mem[2]), 8'hA5);
    chk("fill_rst_m3", int'(mem[3]), 8'hA5);
    chk("fill_rst_m4", int'(mem[4]), 8'h00);
    chk("fill_rst_m5", int'(mem[5]), 8'h00);

    // 2: store then single-byte load; store finishes one cycle after accept.
    do_req(2'b01, 5'd5, 2'd3, 8'h3C);
    chk("store_we", int'(mem_we), 1);
    @(posedge clock);
    #1;
    chk("store_done", int'(busy), 0);
    chk("store_m5", int'(mem[5]), 8'h3C);
    chk("store_m6", int'(mem[6]), 8'h00);
    e.data = 8'h3C; e.last = 1'b1; exp_q.push_back(e);
    do_req(2'b00, 5'd5, 2'd0, 8'h00);
    drain("load5");

    // Reserved op completes in one cycle with no write.
    do_req(2'b11, 5'd9, 2'd3, 8'hFF);
    chk("nop_busy", int'(busy), 0);
    chk("nop_we", int'(mem_we), 0);

    // 3: wrapping fill and load across address 31.
    do_req(2'b10, 5'd30, 2'd3, 8'h55);
    drain("fillwrap");
    chk("wrap_m30", int'(mem[30]), 8'h55);
    chk("wrap_m31", int'(mem[31]), 8'h55);
    chk("wrap_m0",  int'(mem[0]), 8'h55);
    chk("wrap_m1",  int'(mem[1]), 8'h55);
    chk("wrap_m2",  int'(mem[2]), 8'hA5);
    for (int i = 0; i < 4; i++) begin
      e.data = 8'h55; e.last = (i == 3); exp_q.push_back(e);
    end
    do_req(2'b00, 5'd30, 2'd3, 8'h00);
    drain("loadwrap");

    // 4: stall on the second byte of a four-byte load.
    do_req(2'b01, 5'd8, 2'd0, 8'h11);
    do_req(2'b01, 5'd9, 2'd0, 8'h22);
    do_req(2'b01, 5'd10, 2'd0, 8'h33);
    do_req(2'b01, 5'd11, 2'd0, 8'h44);
    @(posedge clock);
    e.data = 8'h11; e.last = 1'b0; exp_q.push_back(e);
    e.data = 8'h22; e.last = 1'b0; exp_q.push_back(e);
    e.data = 8'h33; e.last = 1'b0; exp_q.push_back(e);
    e.data = 8'h44; e.last = 1'b1; exp_q.push_back(e);
    do_req(2'b00, 5'd8, 2'd3, 8'h00);
    chk("load_lat_1", int'(rsp_valid), 0);
    @(posedge clock);
    #1;
    chk("load_lat_2", int'(rsp_valid), 1);
    @(posedge clock);
    #1;
    rsp_ready = 1'b0;
    n = 0;
    while (!rsp_valid && n < 10) begin
      @(negedge clock);
      n++;
    end
    chk("byte2_valid", int'(rsp_valid), 1);
    held = rsp_data;
    chk("byte2_data", int'(held), 8'h22);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("stall_valid", int'(rsp_valid), 1);
      chk("stall_data", int'(rsp_data), int'(held));
      chk("stall_last", int'(rsp_last), 0);
      chk("stall_addr", int'(mem_addr), 9);
    end
    rsp_ready = 1'b1;
    drain("stall");

    // 5: a request held while busy is taken only once the fill completes.
    do_req(2'b10, 5'd14, 2'd3, 8'h66);
    @(negedge clock);
    req_valid = 1'b1;
    req_op    = 2'b01;
    req_addr  = 5'd20;
    req_len   = 2'd0;
    req_wdata = 8'h99;
    n = 0;
    while (!req_ready && n < 20) begin
      chk("held_busy", int'(busy), 1);
      @(negedge clock);
      n++;
    end
    chk("held_wait_cycles", n, 4);
    chk("held_m20_before", int'(mem[20]), 8'h00);
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    drain("held");
    chk("held_m14", int'(mem[14]), 8'h66);
    chk("held_m17", int'(mem[17]), 8'h66);
    chk("held_m18", int'(mem[18]), 8'h00);
    chk("held_m20", int'(mem[20]), 8'h99);

`ifdef LSU_WPROT_EN
    // 6: protected region swallows writes and raises a sticky error.
    do_req(2'b10, 5'd26, 2'd2, 8'hEE);
    drain("prot");
    chk("prot_m26", int'(mem[26]), 8'hEE);
    chk("prot_m27", int'(mem[27]), 8'h00);
    chk("prot_m28", int'(mem[28]), 8'h00);
    repeat (3) @(negedge clock);
    chk("prot_err_sticky", int'(err), 1);
    err_clr = 1'b1;
    @(negedge clock);
    err_clr = 1'b0;
    chk("prot_err_clr", int'(err), 0);
`else
    chk("err_tied", int'(err), 0);
    do_req(2'b01, 5'd28, 2'd0, 8'hEE);
    drain("unprot");
    chk("unprot_m28", int'(mem[28]), 8'hEE);
    chk("err_still_0", int'(err), 0);
`endif

    chk("sb_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
